// File: rtl/cordic_dot_accumulator_pkg.sv
// Shared types and defaults for the CORDIC dot-product accumulator.
package cordic_dot_accumulator_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACCUM = 2'd2,
        OUT   = 2'd3
    } state_t;

    typedef logic signed [7:0]  operand_t;
    typedef logic signed [15:0] product_t;

endpackage

// File: rtl/cordic_dot_sat_add.sv
// Signed W-bit adder with overflow detect; clamps to the signed range when CORDIC_DOT_SAT_EN is defined.
// Latency: combinational. Backpressure: none.
module cordic_dot_sat_add
    import cordic_dot_accumulator_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic signed [W-1:0] raw;

    assign raw = a + b;
    // Overflow only when both operands share a sign and the result flips it.
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef CORDIC_DOT_SAT_EN
    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/cordic_dot_accumulator.sv
// Streams 8-bit operand pairs through an external CORDIC multiplier and accumulates a dot product.
// Latency per element: handshake + 1 ISSUE + multiplier wait + 1 ACCUM. Backpressure: in_ready only in IDLE; result held until res_ready.
// Optional saturation via macro CORDIC_DOT_SAT_EN (default: two's-complement wrap, sat_flag tied low).
module cordic_dot_accumulator
    import cordic_dot_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [7:0]       in_x,
    input  logic signed [7:0]       in_z,
    input  logic                    in_last,
    output logic                    mul_start,
    output logic signed [7:0]       mul_x,
    output logic signed [7:0]       mul_z,
    input  logic signed [15:0]      mul_y,
    input  logic                    mul_done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0]        res_count,
    output logic                    sat_flag
);

`ifdef CORDIC_DOT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_t                  state;
    logic                    last_q;
    product_t                prod_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    acc_ovf;
    logic [CNT_W-1:0]        count;
    logic                    sat_q;

    assign prod_ext  = {{(ACC_W-16){prod_q[15]}}, prod_q};
    assign res_data  = acc;
    assign res_count = count;
    assign sat_flag  = sat_q;

    cordic_dot_sat_add #(.W(ACC_W)) u_add (
        .a   (acc),
        .b   (prod_ext),
        .sum (acc_sum),
        .ovf (acc_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            mul_start <= 1'b0;
            mul_x     <= '0;
            mul_z     <= '0;
            last_q    <= 1'b0;
            prod_q    <= '0;
            acc       <= '0;
            count     <= '0;
            sat_q     <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mul_x     <= in_x;
                        mul_z     <= in_z;
                        last_q    <= in_last;
                        mul_start <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Dropping start here lets the multiplier clear done before the next element.
                    if (mul_done) begin
                        prod_q    <= mul_y;
                        mul_start <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc   <= acc_sum;
                    count <= (&count) ? count : count + CNT_W'(1);
                    sat_q <= sat_q | (acc_ovf & SAT_EN);
                    if (last_q) begin
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                        sat_q     <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
